// File: rtl/dat_init_seq_if.sv
// DAT fill sequencer bus: CPU-side request/status plus the DAT SRAM write/read port.
// With DAT_INIT_VERIFY_EN defined the read-back data and error status are added.
interface dat_init_seq_if #(
    parameter int unsigned TASK_W = 12
);
    localparam int unsigned ADDR_W = TASK_W + 3;

    logic              start;
    logic              task_mode;
    logic [TASK_W-1:0] task_sel;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] dat_addr;
    logic [15:0]       dat_wdata;
    logic              dat_we_l;
    logic              dat_we_h;
`ifdef DAT_INIT_VERIFY_EN
    logic [15:0]       dat_rdata;
    logic              err;
    logic [ADDR_W-1:0] err_addr;

    modport master (
        input  start, task_mode, task_sel, cpu_hold, dat_rdata,
        output busy, done, dat_addr, dat_wdata, dat_we_l, dat_we_h, err, err_addr
    );
    modport slave (
        output start, task_mode, task_sel, cpu_hold, dat_rdata,
        input  busy, done, dat_addr, dat_wdata, dat_we_l, dat_we_h, err, err_addr
    );
`else
    modport master (
        input  start, task_mode, task_sel, cpu_hold,
        output busy, done, dat_addr, dat_wdata, dat_we_l, dat_we_h
    );
    modport slave (
        output start, task_mode, task_sel, cpu_hold,
        input  busy, done, dat_addr, dat_wdata, dat_we_l, dat_we_h
    );
`endif
endinterface

// File: rtl/dat_init_seq.sv
// Fills the DAT SRAM with identity task/slot mappings after reset or on CPU request.
// Optional macro DAT_INIT_VERIFY_EN adds a read-back check cycle after every write.
module dat_init_seq #(
    parameter bit          AUTO_INIT = 1'b1,
    parameter logic [7:0]  FILL_HI   = 8'h00,
    parameter int unsigned TASK_W    = 12
) (
    input  logic           e,
    input  logic           reset,
    dat_init_seq_if.master bus
);
    localparam int unsigned ADDR_W   = TASK_W + 3;
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

`ifdef DAT_INIT_VERIFY_EN
    typedef enum logic [1:0] {IDLE, FILL, DONE, VERIFY} state_t;
`else
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

`ifdef DAT_INIT_VERIFY_EN
    logic              chk_q, chk_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              mismatch_c;

    // Read-back of the previous entry is judged on the edge that ends its read cycle.
    always_comb begin
        mismatch_c = chk_q && !bus.cpu_hold && (state_q == FILL || state_q == DONE)
                     && (bus.dat_rdata != wdata_q);
    end
`endif

    // State and registered outputs; everything advances on the falling edge of e.
    always_ff @(negedge e or posedge reset) begin
        if (reset) begin
            state_q    <= AUTO_INIT ? FILL : IDLE;
            ptr_q      <= '0;
            last_q     <= ADDR_MAX;
            addr_q     <= '0;
            wdata_q    <= {FILL_HI, 8'h00};
            we_q       <= 1'b0;
            busy_q     <= AUTO_INIT;
            done_q     <= 1'b0;
`ifdef DAT_INIT_VERIFY_EN
            chk_q      <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef DAT_INIT_VERIFY_EN
            chk_q      <= chk_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
`endif
        end
    end

    // Next state and next output values.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef DAT_INIT_VERIFY_EN
        chk_d      = chk_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (mismatch_c) begin
            err_d = 1'b1;
            if (!err_q) begin
                err_addr_d = addr_q;
            end
        end
`endif
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    ptr_d   = bus.task_mode ? {bus.task_sel, 3'b000} : '0;
                    last_d  = bus.task_mode ? {bus.task_sel, 3'b111} : ADDR_MAX;
                    busy_d  = 1'b1;
                    state_d = FILL;
`ifdef DAT_INIT_VERIFY_EN
                    chk_d   = 1'b0;
                    err_d   = 1'b0;
`endif
                end
            end
            FILL: begin
                // A held cycle parks on the pending entry and retries it later.
                addr_d = ptr_q;
                if (!bus.cpu_hold) begin
                    wdata_d = {FILL_HI, 5'b0, ptr_q[2:0]};
                    we_d    = 1'b1;
`ifdef DAT_INIT_VERIFY_EN
                    chk_d   = 1'b0;
                    state_d = VERIFY;
`else
                    if (ptr_q == last_q) begin
                        state_d = DONE;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
`endif
                end
            end
`ifdef DAT_INIT_VERIFY_EN
            VERIFY: begin
                if (!bus.cpu_hold) begin
                    chk_d = 1'b1;
                    if (ptr_q == last_q) begin
                        state_d = DONE;
                    end else begin
                        ptr_d   = ptr_q + ADDR_W'(1);
                        state_d = FILL;
                    end
                end
            end
`endif
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
`ifdef DAT_INIT_VERIFY_EN
                chk_d   = 1'b0;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.dat_addr  = addr_q;
    assign bus.dat_wdata = wdata_q;
    assign bus.dat_we_l  = we_q;
    assign bus.dat_we_h  = we_q;
`ifdef DAT_INIT_VERIFY_EN
    assign bus.err       = err_q;
    assign bus.err_addr  = err_addr_q;
`endif

endmodule

// File: tb/tb_dat_init_seq.sv
// Self-checking bench for dat_init_seq: entry-count model plus directed literal checks.
`timescale 1ns/1ps
module tb_dat_init_seq;
    localparam int unsigned TASK_W    = 12;
    localparam logic [7:0]  FILL_HI   = 8'h00;
    localparam bit          AUTO_INIT = 1'b1;
`ifdef DAT_INIT_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam int FULL_CYC = VERIFY ? 65537 : 32769;

    logic e     = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   cmp_en = 1'b0;
    int   cyc;

    dat_init_seq_if #(.TASK_W(TASK_W)) bus ();

    dat_init_seq #(
        .AUTO_INIT(AUTO_INIT),
        .FILL_HI  (FILL_HI),
        .TASK_W   (TASK_W)
    ) dut (
        .e    (e),
        .reset(reset),
        .bus  (bus)
    );

    always #5 e = ~e;

`ifdef DAT_INIT_VERIFY_EN
    // SRAM model powered up with garbage; two locations read back corrupted.
    logic [15:0] mem [0:32767];
    initial for (int i = 0; i < 32768; i++) mem[i] = 16'hDEAD;
    always @(negedge e) if (bus.dat_we_l) mem[bus.dat_addr] <= bus.dat_wdata;
    assign bus.dat_rdata = mem[bus.dat_addr] ^
        ((bus.dat_addr == 15'h0040 || bus.dat_addr == 15'h0050) ? 16'h0100 : 16'h0000);
`endif

    always @(negedge e or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Model: entries left to write, next address, and a pending done pulse.
    int          m_left, m_next;
    bit          m_rd, m_done_pend;
    logic        e_we, e_busy, e_done;
    logic [14:0] e_addr;
    logic [15:0] e_wdata;

    always @(negedge e or posedge reset) begin
        if (reset) begin
            m_left = AUTO_INIT ? 32768 : 0;
            m_next = 0; m_rd = 1'b0; m_done_pend = 1'b0;
            e_we = 1'b0; e_busy = AUTO_INIT; e_done = 1'b0;
            e_addr = 15'h0000; e_wdata = {FILL_HI, 8'h00};
        end else begin
            e_we = 1'b0; e_done = 1'b0;
            if (m_left > 0) begin
                if (bus.cpu_hold) begin
                    e_addr = 15'(m_next);
                end else begin
                    if (!VERIFY || !m_rd) begin
                        e_we    = 1'b1;
                        e_addr  = 15'(m_next);
                        e_wdata = {FILL_HI, 5'b0, 3'(m_next)};
                    end
                    if (VERIFY && !m_rd) begin
                        m_rd = 1'b1;
                    end else begin
                        m_rd   = 1'b0;
                        m_left = m_left - 1;
                        m_next = m_next + 1;
                        if (m_left == 0) m_done_pend = 1'b1;
                    end
                end
            end else if (m_done_pend) begin
                e_done = 1'b1;
                m_done_pend = 1'b0;
            end else if (bus.start) begin
                m_left = bus.task_mode ? 8 : 32768;
                m_next = bus.task_mode ? int'(bus.task_sel) * 8 : 0;
                m_rd   = 1'b0;
            end
            e_busy = (m_left > 0) || m_done_pend;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(posedge e); #1;
            if (cmp_en) begin
                chk("busy",  32'(bus.busy),      32'(e_busy));
                chk("done",  32'(bus.done),      32'(e_done));
                chk("we_l",  32'(bus.dat_we_l),  32'(e_we));
                chk("we_h",  32'(bus.dat_we_h),  32'(e_we));
                chk("addr",  32'(bus.dat_addr),  32'(e_addr));
                chk("wdata", 32'(bus.dat_wdata), 32'(e_wdata));
            end
        end
    endtask

    task automatic wait_write(input logic [14:0] a, input int max);
        bit found = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            @(posedge e); #2;
            if (bus.dat_we_l && bus.dat_addr == a) found = 1'b1;
        end
        chk("write_seen", 32'(found), 32'(1));
    endtask

    task automatic wait_done(input int max, output int n);
        bit found = 1'b0;
        n = -1;
        for (int i = 0; i < max && !found; i++) begin
            @(posedge e); #2;
            if (bus.done) begin
                found = 1'b1;
                n = cyc;
            end
        end
        chk("done_seen", 32'(found), 32'(1));
    endtask

    task automatic pulse_start(input logic mode, input logic [11:0] sel, output int base);
        bus.start = 1'b1; bus.task_mode = mode; bus.task_sel = sel;
        @(posedge e); #2;
        bus.start = 1'b0; bus.task_mode = 1'b0;
        base = cyc;
    endtask

    initial begin
        int n, base;
        fork compare_loop(); join_none
        bus.start = 1'b0; bus.task_mode = 1'b0; bus.task_sel = '0; bus.cpu_hold = 1'b0;
        repeat (3) @(posedge e);
        #2;
        chk("rst_busy",  32'(bus.busy),      32'(1));
        chk("rst_done",  32'(bus.done),      32'(0));
        chk("rst_we",    32'(bus.dat_we_l),  32'(0));
        chk("rst_addr",  32'(bus.dat_addr),  32'(0));
        chk("rst_wdata", 32'(bus.dat_wdata), 32'(16'h0000));
`ifdef DAT_INIT_VERIFY_EN
        chk("rst_err",   32'(bus.err),       32'(0));
`endif
        cmp_en = 1'b1;
        reset  = 1'b0;

        // Auto full fill, with an ignored start pulse in the middle.
        wait_write(15'h0005, 100);
        chk("wdata_0005", 32'(bus.dat_wdata), 32'(16'h0005));
`ifdef DAT_INIT_VERIFY_EN
        wait_write(15'h003F, 200);
        chk("err_before", 32'(bus.err), 32'(0));
`endif
        wait_write(15'h00FF, 2000);
        pulse_start(1'b1, 12'h001, base);
        wait_write(15'h7FFF, 70000);
        chk("wdata_7fff", 32'(bus.dat_wdata), 32'(16'h0007));
        wait_done(5, n);
        chk("full_cycles", 32'(n), 32'(FULL_CYC));
        chk("done_busy",   32'(bus.busy), 32'(0));
`ifdef DAT_INIT_VERIFY_EN
        chk("err_set",  32'(bus.err),      32'(1));
        chk("err_addr", 32'(bus.err_addr), 32'(15'h0040));
`endif

        // Single-task fill of task 0x023.
        pulse_start(1'b1, 12'h023, base);
`ifdef DAT_INIT_VERIFY_EN
        chk("err_clear", 32'(bus.err), 32'(0));
`endif
        wait_write(15'h0118, 3);
        chk("wdata_0118", 32'(bus.dat_wdata), 32'(16'h0000));
        wait_write(15'h011F, 20);
        chk("wdata_011f", 32'(bus.dat_wdata), 32'(16'h0007));
        wait_done(5, n);
        chk("task_cycles", 32'(n - base), 32'(VERIFY ? 17 : 9));

        // Task fill with a 3-cycle CPU hold when entry 0x11A is next.
        pulse_start(1'b1, 12'h023, base);
        wait_write(15'h0119, 10);
        bus.cpu_hold = 1'b1;
        repeat (3) begin
            @(posedge e); #2;
            chk("hold_we",   32'(bus.dat_we_l), 32'(0));
            chk("hold_addr", 32'(bus.dat_addr), 32'(VERIFY ? 15'h0119 : 15'h011A));
        end
        bus.cpu_hold = 1'b0;
        @(posedge e); #2;
        chk("resume_we",   32'(bus.dat_we_l), 32'(!VERIFY));
        chk("resume_addr", 32'(bus.dat_addr), 32'(VERIFY ? 15'h0119 : 15'h011A));
        wait_done(30, n);
        chk("hold_cycles", 32'(n - base), 32'(VERIFY ? 20 : 12));

        // Full fill aborted by reset, then automatic restart from 0000.
        pulse_start(1'b0, 12'h000, base);
        wait_write(15'h1233, 12000);
        reset = 1'b1;
        #1;
        chk("abort_we_l", 32'(bus.dat_we_l), 32'(0));
        chk("abort_we_h", 32'(bus.dat_we_h), 32'(0));
        chk("abort_addr", 32'(bus.dat_addr), 32'(0));
        repeat (2) @(posedge e);
        #2;
        reset = 1'b0;
        @(posedge e); #2;
        chk("restart_we",   32'(bus.dat_we_l), 32'(1));
        chk("restart_addr", 32'(bus.dat_addr), 32'(0));
        chk("restart_busy", 32'(bus.busy),     32'(1));
        repeat (200) @(posedge e);
        #2;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dat_init_seq.md
Name: dat_init_seq

Overview:
- Upstream fill engine for the external 32K x 16 DAT SRAM read by the MMU translation stage.
- DAT SRAM powers up with garbage, so the MMU must not be enabled until the DAT holds valid data.
- After reset, and again on CPU request, this block writes identity mappings: every slot s of a task maps to board bank s (bank bits [7:3] = 0).
- Top level muxes its address, data and strobes onto the DAT bus while busy is high.

Parameters:
- AUTO_INIT, 1: full-DAT fill starts automatically after reset release.
- FILL_HI, 8'h00: value written to the DAT high byte (extended MMU bits).
- TASK_W, 12: task number width. DAT address = {task, slot[2:0]}, so it is 15 bits.

Ports:
- e  input  1: 6809 E clock. All state advances on the falling edge of e.
- reset  input  1: asynchronous, active-high reset.
- start  input  1: one-cycle request, sampled on the e falling edge.
- task_mode  input  1: 1 = fill the single task task_sel; 0 = fill the entire DAT. Sampled with start.
- task_sel  input  TASK_W: task to fill when task_mode=1. Sampled with start.
- cpu_hold  input  1: CPU is using the DAT bus (ce_dat) this cycle, so the sequencer must stall.
- busy  output  1: fill in progress. Top level forces the MMU off and grants the DAT bus to this block.
- done  output  1: one-cycle pulse after the last entry is written.
- dat_addr  output  15: DAT SRAM address.
- dat_wdata  output  16: DAT write data.
- dat_we_l  output  1: low-byte write request. Top level ANDs it with e.
- dat_we_h  output  1: high-byte write request. Top level ANDs it with e.

Behaviour:
- Registered outputs. All outputs are registered, so write requests are stable through the whole high phase of e.
- Reset values:
  - busy = AUTO_INIT.
  - done = 0.
  - dat_addr = 0.
  - dat_wdata = {FILL_HI, 8'h00}.
  - dat_we_l = dat_we_h = 0.
  - State = FILL if AUTO_INIT=1, otherwise IDLE.
  - Pointer ptr = 0, last = 15'h7FFF.
- States: IDLE, FILL, DONE. The extra state VERIFY exists only with the optional feature.
- IDLE:
  - busy=0, no writes.
  - start=1 latches the range:
    - task_mode=1: ptr = {task_sel, 3'b000}, last = {task_sel, 3'b111}.
    - task_mode=0: ptr = 0, last = 15'h7FFF.
  - Then go to FILL. busy rises on the same edge.
- FILL, each e cycle:
  - cpu_hold=0:
    - dat_addr = ptr.
    - dat_wdata = {FILL_HI, 5'b0, ptr[2:0]}.
    - dat_we_l = dat_we_h = 1.
    - If ptr == last, go to DONE. Otherwise ptr = ptr + 1.
  - cpu_hold=1:
    - Write requests drop to 0.
    - ptr and dat_addr hold.
    - No increment; the same entry is retried the next cycle.
  - Throughput: 1 entry per unheld cycle. Full fill = 32768 cycles; task fill = 8 cycles.
- DONE: done=1 and busy=0 for exactly one cycle, write requests 0, then return to IDLE.
- Wrap-around: ptr never wraps past last, because the ptr == last check runs before the increment. A full fill ends at 7FFF without rolling to 0000.
- start while busy (FILL or DONE): ignored. No re-latch of task_sel or task_mode.
- start and reset together: reset wins.
- Reset mid-fill: abort immediately (asynchronous).
  - All outputs go to their reset values.
  - With AUTO_INIT=1, a full fill restarts from 0000 after release. A partially written DAT is acceptable because busy holds the MMU off.
- cpu_hold while IDLE or DONE: no effect.

Optional Feature:
- Macro: DAT_INIT_VERIFY_EN.
- Adds ports:
  - dat_rdata  input  16: DAT read data.
  - err  output  1: sticky mismatch flag, reset 0, cleared by an accepted start.
  - err_addr  output  15: address of the first mismatch, reset 0.
- Each entry takes 2 unheld cycles:
  - FILL: write cycle.
  - VERIFY: same dat_addr, write requests 0. dat_rdata is compared with the expected word on the e falling edge.
- On a mismatch:
  - err=1.
  - err_addr captured only if err was 0.
  - The fill continues.
- cpu_hold stalls VERIFY the same way as FILL.
- Without the macro: no extra ports, 1 cycle per entry, no VERIFY state.

Test Plan:
1. AUTO_INIT=1, release reset, cpu_hold=0:
   - busy=1 from reset.
   - Writes run at dat_addr 0000..7FFF.
   - dat_wdata at 0x0005 = 0x0005 and at 0x7FFF = 0x0007.
   - done pulses one cycle after the 7FFF write; busy drops on that cycle. Total 32769 cycles.
2. Idle, start with task_mode=1, task_sel=0x023:
   - Writes at 0x118..0x11F with data 0x0000..0x0007.
   - done pulses on cycle 9.
   - No write outside that range.
3. Task fill 0x023 with cpu_hold=1 for 3 cycles while ptr=0x11A:
   - Write requests stay 0 and dat_addr holds 0x11A for those 3 cycles.
   - The fill resumes at 0x11A; done pulses on cycle 12.
4. Pulse start (task_mode=1, task_sel=0x001) during a full fill at ptr=0x0100:
   - Ignored; the fill continues to 7FFF.
   - last and ptr are unchanged by the pulse.
5. Assert reset at ptr=0x1234 mid-edge:
   - Write requests go to 0 immediately.
   - After release, writes restart at 0000 with busy=1.
6. DAT_INIT_VERIFY_EN, force dat_rdata mismatch at 0x0040 and 0x0050:
   - err=1, err_addr=0x0040.
   - Full fill completes in 65537 cycles.
   - The next accepted start clears err.
